// File: rtl/lsb_queue_if.sv
// ---------------------------------------------------------------------------
// lsb_queue_if
//   Memory-controller request/response bus of the load/store buffer.
//   One request is outstanding at a time; mem_en is held until mem_done.
//
//   Signals
//     mem_en     LSB -> mem  request valid, held until mem_done
//     mem_wr     LSB -> mem  1 = write, 0 = read
//     mem_a      LSB -> mem  byte address
//     mem_len    LSB -> mem  access size in bytes (1, 2 or 4)
//     mem_s      LSB -> mem  store data, low mem_len bytes used
//     mem_done   mem -> LSB  one-cycle completion pulse
//     mem_rdata  mem -> LSB  load data, valid with mem_done
//
//   Modports
//     master  the load/store buffer
//     slave   the memory controller (or a bench model of it)
// ---------------------------------------------------------------------------
interface lsb_queue_if #(
    parameter int XLEN = 32
);
    logic            mem_en;
    logic            mem_wr;
    logic [XLEN-1:0] mem_a;
    logic [2:0]      mem_len;
    logic [XLEN-1:0] mem_s;
    logic            mem_done;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_en, mem_wr, mem_a, mem_len, mem_s,
        input  mem_done, mem_rdata
    );

    modport slave (
        input  mem_en, mem_wr, mem_a, mem_len, mem_s,
        output mem_done, mem_rdata
    );
endinterface

// File: rtl/lsb_queue.sv
// ---------------------------------------------------------------------------
// lsb_queue
//   In-order load/store buffer for the out-of-order RV32I core. Holds up to
//   DEPTH = 1 << DEPTH_LOG memory ops between issue, ROB and the memory
//   controller. Entries snoop the ALU CDB and this block's own load CDB for
//   missing operands. The head entry is sent to memory once its operands are
//   ready: ordinary loads go speculatively, stores and IO loads (address >=
//   IO_BASE) wait for the ROB commit. Rollback keeps committed stores only.
//
//   Optional feature (compile-time macro LSB_CDB_BYPASS_EN):
//     defined   - an operand arriving not-ready whose tag matches a CDB
//                 broadcast in the enqueue cycle is stored ready with the
//                 broadcast value.
//     undefined - the operand is stored not-ready; the issue stage is
//                 expected to bypass that broadcast itself.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     rdy                 global enable; all state frozen while low
//     rollback            mispredict flush
//     full                count >= DEPTH-1 (one slot of issue-latency margin)
//     iss_*               enqueue request and operands from the issue stage
//     cmt_en/cmt_rob_pos  ROB commit of a store or IO load
//     alu_*               ALU result broadcast (CDB)
//     mem                 memory bus, lsb_queue_if.master
//     done/res/res_rob_pos  load result broadcast (one-cycle pulse)
//
//   The mem interface instance must be built with the same XLEN.
// ---------------------------------------------------------------------------
module lsb_queue #(
    parameter int              DEPTH_LOG = 4,
    parameter int              ROB_W     = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] IO_BASE   = 'h30000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             rollback,
    output logic             full,

    input  logic             iss_en,
    input  logic [ROB_W-1:0] iss_rob_pos,
    input  logic             iss_ls,
    input  logic [2:0]       iss_funct3,
    input  logic             iss_rs1_rdy,
    input  logic [XLEN-1:0]  iss_rs1_val,
    input  logic [ROB_W-1:0] iss_rs1_tag,
    input  logic             iss_rs2_rdy,
    input  logic [XLEN-1:0]  iss_rs2_val,
    input  logic [ROB_W-1:0] iss_rs2_tag,
    input  logic [XLEN-1:0]  iss_imm,

    input  logic             cmt_en,
    input  logic [ROB_W-1:0] cmt_rob_pos,

    input  logic             alu_done,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [ROB_W-1:0] alu_rob_pos,

    lsb_queue_if.master      mem,

    output logic             done,
    output logic [XLEN-1:0]  res,
    output logic [ROB_W-1:0] res_rob_pos
);

    localparam int               DEPTH     = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Access size in bytes from funct3[1:0]: byte, half, word.
    function automatic logic [2:0] access_len(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Load result extension: LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [XLEN-1:0] w;
        b = d[7:0];
        h = d[15:0];
        case (f3)
            3'b000:  w = XLEN'(b);
            3'b001:  w = XLEN'(h);
            3'b100:  w = XLEN'(d[7:0]);
            3'b101:  w = XLEN'(d[15:0]);
            default: w = d;
        endcase
        return $unsigned(w);
    endfunction

    // Ring pointers and occupancy
    logic [DEPTH_LOG-1:0] head_q, tail_q;
    logic [DEPTH_LOG:0]   count_q;
    state_t               state_q, state_d;

    // Per-entry control bits
    logic [DEPTH-1:0] busy_q, cmt_q, rs1_rdy_q, rs2_rdy_q;

    // Per-entry payload
    logic [DEPTH-1:0] ls_q;
    logic [2:0]       f3_q      [DEPTH];
    logic [ROB_W-1:0] pos_q     [DEPTH];
    logic [ROB_W-1:0] rs1_tag_q [DEPTH];
    logic [ROB_W-1:0] rs2_tag_q [DEPTH];
    logic [XLEN-1:0]  rs1_val_q [DEPTH];
    logic [XLEN-1:0]  rs2_val_q [DEPTH];
    logic [XLEN-1:0]  imm_q     [DEPTH];

    // Registered memory request
    logic            mem_en_q, mem_wr_q;
    logic [XLEN-1:0] mem_a_q, mem_s_q;
    logic [2:0]      mem_len_q;

    assign mem.mem_en  = mem_en_q;
    assign mem.mem_wr  = mem_wr_q;
    assign mem.mem_a   = mem_a_q;
    assign mem.mem_len = mem_len_q;
    assign mem.mem_s   = mem_s_q;

    assign full = (count_q >= FULL_CNT);

    // Operand snoop hits per entry
    logic [DEPTH-1:0] s1_alu, s1_cdb, s2_alu, s2_cdb;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s1_alu[i] = busy_q[i] && !rs1_rdy_q[i] && alu_done && (rs1_tag_q[i] == alu_rob_pos);
            s1_cdb[i] = busy_q[i] && !rs1_rdy_q[i] && done     && (rs1_tag_q[i] == res_rob_pos);
            s2_alu[i] = busy_q[i] && !rs2_rdy_q[i] && alu_done && (rs2_tag_q[i] == alu_rob_pos);
            s2_cdb[i] = busy_q[i] && !rs2_rdy_q[i] && done     && (rs2_tag_q[i] == res_rob_pos);
        end
    end

    // Operands as written into a newly enqueued entry
    logic            in_rs1_rdy, in_rs2_rdy;
    logic [XLEN-1:0] in_rs1_val, in_rs2_val;

    always_comb begin
        in_rs1_rdy = iss_rs1_rdy;
        in_rs1_val = iss_rs1_val;
        in_rs2_rdy = iss_rs2_rdy;
        in_rs2_val = iss_rs2_val;
`ifdef LSB_CDB_BYPASS_EN
        if (!iss_rs1_rdy && alu_done && (iss_rs1_tag == alu_rob_pos)) begin
            in_rs1_rdy = 1'b1;
            in_rs1_val = alu_res;
        end else if (!iss_rs1_rdy && done && (iss_rs1_tag == res_rob_pos)) begin
            in_rs1_rdy = 1'b1;
            in_rs1_val = res;
        end
        if (!iss_rs2_rdy && alu_done && (iss_rs2_tag == alu_rob_pos)) begin
            in_rs2_rdy = 1'b1;
            in_rs2_val = alu_res;
        end else if (!iss_rs2_rdy && done && (iss_rs2_tag == res_rob_pos)) begin
            in_rs2_rdy = 1'b1;
            in_rs2_val = res;
        end
`endif
    end

    // Committed entries are contiguous from head, so their count gives the
    // tail position that survives a rollback.
    logic [DEPTH_LOG:0] ncommit;

    always_comb begin
        ncommit = '0;
        for (int i = 0; i < DEPTH; i++)
            ncommit = ncommit + (DEPTH_LOG+1)'(busy_q[i] & cmt_q[i]);
    end

    // Head entry readiness
    logic [XLEN-1:0] head_addr;
    logic            head_io, head_ready, head_cmt, head_ls;

    assign head_addr = rs1_val_q[head_q] + imm_q[head_q];
    assign head_io   = (head_addr >= IO_BASE);
    assign head_cmt  = cmt_q[head_q];
    assign head_ls   = ls_q[head_q];

    always_comb begin
        head_ready = busy_q[head_q] && rs1_rdy_q[head_q];
        if (head_ls)
            head_ready = head_ready && rs2_rdy_q[head_q] && head_cmt;
        else
            head_ready = head_ready && (!head_io || head_cmt);
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else if (rdy)
            state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (head_ready && (!rollback || head_cmt)) state_d = BUSY;
            BUSY: begin
                if (mem.mem_done)
                    state_d = IDLE;
                else if (rollback && !head_cmt)
                    state_d = DRAIN;    // flushed load in flight: swallow its reply
            end
            DRAIN: if (mem.mem_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: control outputs ----
    logic start, deq, ld_done, enq, mem_clr;

    always_comb begin
        start   = (state_q == IDLE) && head_ready && (!rollback || head_cmt);
        // A reply for an access that the same-cycle rollback flushes is dropped.
        deq     = (state_q == BUSY) && mem.mem_done && (!rollback || head_cmt);
        ld_done = deq && !head_ls && !rollback;
        mem_clr = (state_q != IDLE) && mem.mem_done;
        enq     = iss_en && (count_q != DEPTH_CNT) && !rollback;
    end

    // ---- Ring pointers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            head_q <= head_q + DEPTH_LOG'(deq);
            if (rollback) begin
                tail_q  <= head_q + ncommit[DEPTH_LOG-1:0];
                count_q <= ncommit - (DEPTH_LOG+1)'(deq);
            end else begin
                tail_q  <= tail_q + DEPTH_LOG'(enq);
                count_q <= count_q + (DEPTH_LOG+1)'(enq) - (DEPTH_LOG+1)'(deq);
            end
        end
    end

    // ---- Entry control bits ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            cmt_q     <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (s1_alu[i] || s1_cdb[i])
                    rs1_rdy_q[i] <= 1'b1;
                if (s2_alu[i] || s2_cdb[i])
                    rs2_rdy_q[i] <= 1'b1;
                if (!rollback && cmt_en && busy_q[i] && (pos_q[i] == cmt_rob_pos))
                    cmt_q[i] <= 1'b1;
                if (rollback && !cmt_q[i])
                    busy_q[i] <= 1'b0;
                if (deq && (head_q == DEPTH_LOG'(i))) begin
                    busy_q[i] <= 1'b0;
                    cmt_q[i]  <= 1'b0;
                end
                if (enq && (tail_q == DEPTH_LOG'(i))) begin
                    busy_q[i]    <= 1'b1;
                    cmt_q[i]     <= 1'b0;
                    rs1_rdy_q[i] <= in_rs1_rdy;
                    rs2_rdy_q[i] <= in_rs2_rdy;
                end
            end
        end
    end

    // ---- Entry payload ----
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && (tail_q == DEPTH_LOG'(i))) begin
                    ls_q[i]      <= iss_ls;
                    f3_q[i]      <= iss_funct3;
                    pos_q[i]     <= iss_rob_pos;
                    rs1_tag_q[i] <= iss_rs1_tag;
                    rs2_tag_q[i] <= iss_rs2_tag;
                    rs1_val_q[i] <= in_rs1_val;
                    rs2_val_q[i] <= in_rs2_val;
                    imm_q[i]     <= iss_imm;
                end else begin
                    if (s1_alu[i])
                        rs1_val_q[i] <= alu_res;
                    else if (s1_cdb[i])
                        rs1_val_q[i] <= res;
                    if (s2_alu[i])
                        rs2_val_q[i] <= alu_res;
                    else if (s2_cdb[i])
                        rs2_val_q[i] <= res;
                end
            end
        end
    end

    // ---- Memory request and load result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_len_q   <= '0;
            mem_s_q     <= '0;
            done        <= 1'b0;
            res         <= '0;
            res_rob_pos <= '0;
        end else if (rdy) begin
            if (start) begin
                mem_en_q  <= 1'b1;
                mem_wr_q  <= head_ls;
                mem_a_q   <= head_addr;
                mem_len_q <= access_len(f3_q[head_q]);
                mem_s_q   <= rs2_val_q[head_q];
            end else if (mem_clr) begin
                mem_en_q <= 1'b0;
            end
            done <= ld_done;
            if (ld_done) begin
                res         <= load_extend(f3_q[head_q], mem.mem_rdata);
                res_rob_pos <= pos_q[head_q];
            end
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
module tb_lsb_queue;
    localparam int DEPTH_LOG = 2;
    localparam int ROB_W     = 4;
    localparam int XLEN      = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, rdy, rollback, full;
    logic             iss_en, iss_ls, iss_rs1_rdy, iss_rs2_rdy;
    logic [ROB_W-1:0] iss_rob_pos, iss_rs1_tag, iss_rs2_tag;
    logic [2:0]       iss_funct3;
    logic [XLEN-1:0]  iss_rs1_val, iss_rs2_val, iss_imm;
    logic             cmt_en;
    logic [ROB_W-1:0] cmt_rob_pos;
    logic             alu_done;
    logic [XLEN-1:0]  alu_res;
    logic [ROB_W-1:0] alu_rob_pos;
    logic             done;
    logic [XLEN-1:0]  res;
    logic [ROB_W-1:0] res_rob_pos;

    lsb_queue_if #(.XLEN(XLEN)) m ();

    lsb_queue #(.DEPTH_LOG(DEPTH_LOG), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .full(full),
        .iss_en(iss_en), .iss_rob_pos(iss_rob_pos), .iss_ls(iss_ls), .iss_funct3(iss_funct3),
        .iss_rs1_rdy(iss_rs1_rdy), .iss_rs1_val(iss_rs1_val), .iss_rs1_tag(iss_rs1_tag),
        .iss_rs2_rdy(iss_rs2_rdy), .iss_rs2_val(iss_rs2_val), .iss_rs2_tag(iss_rs2_tag),
        .iss_imm(iss_imm), .cmt_en(cmt_en), .cmt_rob_pos(cmt_rob_pos),
        .alu_done(alu_done), .alu_res(alu_res), .alu_rob_pos(alu_rob_pos),
        .mem(m), .done(done), .res(res), .res_rob_pos(res_rob_pos)
    );

    typedef struct { logic wr; logic [31:0] a; logic [2:0] len; logic [31:0] d; } mreq_t;
    typedef struct { logic [3:0] pos; logic [31:0] v; } res_t;

    mreq_t memq[$];
    res_t  resq[$];
    int    tests = 0;
    int    fails = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    bit    resp_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'h0, d[7:0]};
            3'b101:  return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [2:0] tb_len(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 3'd1;
        if (f3[1:0] == 2'b01) return 3'd2;
        return 3'd4;
    endfunction

    // Memory model: checks each request against the expected queue and
    // replies after a random latency.
    initial begin : responder
        int    cnt;
        mreq_t e;
        cnt = 0;
        m.mem_done  = 1'b0;
        m.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (m.mem_done) begin
                m.mem_done = 1'b0;
                resp_busy  = 1'b0;
            end else if (resp_busy) begin
                if (cnt == 0) m.mem_done = 1'b1;
                else cnt--;
            end else if (m.mem_en === 1'b1) begin
                resp_busy = 1'b1;
                cnt = $urandom_range(lat_max, lat_min);
                tests++;
                assert (memq.size() > 0) else begin
                    fails++;
                    $error("FAIL mem_unexpected: observed request wr=%0b a=%h expected none", m.mem_wr, m.mem_a);
                end
                if (memq.size() > 0) begin
                    e = memq.pop_front();
                    chk("mem_wr", 32'(m.mem_wr), 32'(e.wr));
                    chk("mem_a", m.mem_a, e.a);
                    chk("mem_len", 32'(m.mem_len), 32'(e.len));
                    if (e.wr) chk("mem_s", m.mem_s, e.d);
                    m.mem_rdata = e.d;
                end
                if (cnt == 0) m.mem_done = 1'b1;
            end
        end
    end

    // Result scoreboard
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                tests++;
                assert (resq.size() > 0) else begin
                    fails++;
                    $error("FAIL res_unexpected: observed done pos=%0d res=%h expected none", res_rob_pos, res);
                end
                if (resq.size() > 0) begin
                    r = resq.pop_front();
                    chk("res_rob_pos", 32'(res_rob_pos), 32'(r.pos));
                    chk("res", res, r.v);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic ls, input logic [2:0] f3, input logic [3:0] rob,
                         input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                         input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag,
                         input logic [31:0] imm);
        iss_en = 1'b1; iss_ls = ls; iss_funct3 = f3; iss_rob_pos = rob;
        iss_rs1_rdy = r1rdy; iss_rs1_val = r1val; iss_rs1_tag = r1tag;
        iss_rs2_rdy = r2rdy; iss_rs2_val = r2val; iss_rs2_tag = r2tag;
        iss_imm = imm;
        @(negedge clk);
        iss_en = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        cmt_en = 1'b1; cmt_rob_pos = rob;
        @(negedge clk);
        cmt_en = 1'b0;
    endtask

    task automatic pulse_rollback();
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
    endtask

    task automatic load(input logic [3:0] rob, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rdata);
        memq.push_back('{1'b0, addr, tb_len(f3), rdata});
        resq.push_back('{rob, tb_ext(f3, rdata)});
        issue(1'b0, f3, rob, 1'b1, addr, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic store(input logic [3:0] rob, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        memq.push_back('{1'b1, addr, tb_len(f3), data});
        issue(1'b1, f3, rob, 1'b1, addr, 4'd0, 1'b1, data, 4'd0, 32'd0);
        commit(rob);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((memq.size() != 0 || resq.size() != 0 || resp_busy || m.mem_en === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic wait_not_full();
        int n;
        n = 0;
        while (full === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_not_full", 32'(n < 300), 32'd1);
    endtask

    initial begin : stim
        logic [2:0] lf3 [5];
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
        iss_en = 1'b0; iss_ls = 1'b0; iss_funct3 = '0; iss_rob_pos = '0;
        iss_rs1_rdy = 1'b0; iss_rs1_val = '0; iss_rs1_tag = '0;
        iss_rs2_rdy = 1'b0; iss_rs2_val = '0; iss_rs2_tag = '0; iss_imm = '0;
        cmt_en = 1'b0; cmt_rob_pos = '0;
        alu_done = 1'b0; alu_res = '0; alu_rob_pos = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Reset state
        chk("rst_mem_en", 32'(m.mem_en), 32'd0);
        chk("rst_mem_wr", 32'(m.mem_wr), 32'd0);
        chk("rst_mem_a", m.mem_a, 32'd0);
        chk("rst_mem_len", 32'(m.mem_len), 32'd0);
        chk("rst_mem_s", m.mem_s, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_res_rob_pos", 32'(res_rob_pos), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        // LW rob 3, base 0x100 + imm 4
        memq.push_back('{1'b0, 32'h104, 3'd4, 32'hDEADBEEF});
        resq.push_back('{4'd3, 32'hDEADBEEF});
        issue(1'b0, 3'b010, 4'd3, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0, 4'd0, 32'd4);
        drain("drain_lw");

        // LB then LBU of 0x80
        load(4'd4, 3'b000, 32'h200, 32'h00000080);
        load(4'd6, 3'b100, 32'h201, 32'h00000080);
        drain("drain_lb_lbu");

        // SW waiting for its data via the ALU CDB and then for commit
        issue(1'b1, 3'b010, 4'd5, 1'b1, 32'h200, 4'd0, 1'b0, 32'd0, 4'd2, 32'd0);
        alu_done = 1'b1; alu_rob_pos = 4'd2; alu_res = 32'h55;
        cyc(1);
        alu_done = 1'b0;
        cyc(4);
        chk("sw_hold", 32'(m.mem_en), 32'd0);
        memq.push_back('{1'b1, 32'h200, 3'd4, 32'h55});
        commit(4'd5);
        drain("drain_sw");

        // IO load waits for commit; the word below IO_BASE does not
        issue(1'b0, 3'b010, 4'd7, 1'b1, 32'h30000, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        cyc(4);
        chk("io_hold", 32'(m.mem_en), 32'd0);
        memq.push_back('{1'b0, 32'h30000, 3'd4, 32'h12345678});
        resq.push_back('{4'd7, 32'h12345678});
        commit(4'd7);
        drain("drain_io");
        load(4'd8, 3'b010, 32'h2FFFC, 32'hCAFEF00D);
        drain("drain_below_io");

        // Fill to full, commit the head store, rollback the rest
        issue(1'b1, 3'b010, 4'd9, 1'b1, 32'h300, 4'd0, 1'b1, 32'h77, 4'd0, 32'd0);
        issue(1'b0, 3'b010, 4'd10, 1'b1, 32'h310, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        issue(1'b0, 3'b010, 4'd11, 1'b1, 32'h314, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("full_set", 32'(full), 32'd1);
        memq.push_back('{1'b1, 32'h300, 3'd4, 32'h77});
        commit(4'd9);
        pulse_rollback();
        chk("full_after_rollback", 32'(full), 32'd0);
        drain("drain_rollback_sw");

        // Occupancy after rollback: two entries not full, three full
        issue(1'b0, 3'b010, 4'd1, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0, 32'd0);
        issue(1'b0, 3'b010, 4'd2, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("count2_not_full", 32'(full), 32'd0);
        issue(1'b0, 3'b010, 4'd3, 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("count3_full", 32'(full), 32'd1);
        pulse_rollback();
        chk("flush_all", 32'(full), 32'd0);

        // rdy low: enqueue is lost
        rdy = 1'b0;
        issue(1'b0, 3'b010, 4'd3, 1'b1, 32'h500, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        cyc(3);
        chk("rdy_freeze", 32'(m.mem_en), 32'd0);
        rdy = 1'b1;
        cyc(3);
        chk("rdy_lost_issue", 32'(m.mem_en), 32'd0);

        // Rollback of an in-flight speculative load: reply swallowed
        lat_min = 6; lat_max = 6;
        memq.push_back('{1'b0, 32'h400, 3'd4, 32'h0BADF00D});
        issue(1'b0, 3'b010, 4'd13, 1'b1, 32'h400, 4'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        cyc(3);
        chk("drain_in_flight", 32'(m.mem_en), 32'd1);
        pulse_rollback();
        drain("drain_flushed_load");
        chk("drain_mem_en", 32'(m.mem_en), 32'd0);
        lat_min = 1; lat_max = 1;
        load(4'd14, 3'b001, 32'h402, 32'h0000_8001);
        drain("drain_after_flush");

        // Wrap: mixed ops with random memory latency
        lat_min = 0; lat_max = 3;
        for (int k = 0; k < 12; k++) begin
            wait_not_full();
            if (k % 3 == 2)
                store(4'(k), 3'($urandom_range(0, 2)), 32'h1000 + 32'(k * 4), $urandom);
            else
                load(4'(k), lf3[$urandom_range(0, 4)], 32'h2000 + 32'(k * 4), $urandom);
        end
        drain("drain_wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
